skin_mask_binarizer: RTL
========================

SKIN_MASK_BINARIZER -- requirements
Module: skin_mask_binarizer

Interface
REQ-001 Parameter IMG_W, default 640, active pixels per line.
REQ-002 Parameter IMG_H, default 480, active lines per frame.
REQ-003 Parameter THR_INIT, default 20'd524288, threshold for the first frame after reset.
REQ-004 clk  in  1  rising-edge clock, shared with gaussian_function.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 in_valid  in  1  gauss_A carries a valid pixel likelihood this cycle.
REQ-007 in_sof  in  1  start of frame; qualified by in_valid; marks the first pixel.
REQ-008 gauss_A  in  20  unsigned likelihood from gaussian_function.
REQ-009 thr_num  in  4  threshold fraction numerator over 16; sampled only at frame end.
REQ-010 mask_valid  out  1  mask carries a valid bit.
REQ-011 mask  out  1  1 = skin pixel.
REQ-012 mask_sof  out  1  aligned copy of in_sof for the first mask bit.
REQ-013 frame_done  out  1  one-cycle pulse after the last pixel's mask is output.
REQ-014 frame_max  out  20  maximum gauss_A of the last completed frame.
REQ-015 skin_count  out  19  number of mask=1 pixels in the last completed frame.
REQ-016 err_sync  out  1  one-cycle pulse on in_sof received mid-frame.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACTIVE and DONE.
REQ-018 IDLE: a pixel with in_valid=1 and in_sof=0 SHALL be discarded, with no mask_valid; in_valid=1 and in_sof=1 SHALL accept the pixel as pixel 0 and move to ACTIVE.
REQ-019 ACTIVE: each in_valid pixel SHALL be accepted and the 19-bit pixel counter incremented; acceptance of pixel IMG_W*IMG_H-1 SHALL move to DONE.
REQ-020 ACTIVE with in_valid=1 and in_sof=1 SHALL pulse err_sync, discard the partial frame accumulators without updating outputs or threshold, and restart the frame with this pixel as pixel 0.
REQ-021 DONE SHALL last one cycle and behave like IDLE for input; it SHALL return to IDLE, or to ACTIVE on a sof pixel.
REQ-022 The decision SHALL be mask = (gauss_A > thr), a strict unsigned compare.
REQ-023 thr SHALL be a register: THR_INIT after reset; at acceptance of the last pixel it SHALL load (max_new * thr_num) >> 4, using a 24-bit product truncated to 20 bits, where max_new includes the last pixel.
REQ-024 At the same edge, frame_max SHALL load max_new and skin_count SHALL load the running count including the last pixel's decision.
REQ-025 thr_num=0 SHALL give thr=0, so every nonzero pixel is skin in the next frame.
REQ-026 The running max and skin counters SHALL clear at every accepted sof pixel.
REQ-027 Latency SHALL be exactly 2 cycles from accepted input to mask_valid/mask/mask_sof, which are registered, with no bubbles and one output per accepted pixel.
REQ-028 frame_done SHALL assert in the cycle after the last pixel's mask_valid.
REQ-029 The block SHALL have no backpressure; in_valid may be high every cycle.

Reset
REQ-030 While rst_n=0 at a rising edge, the block SHALL set FSM=IDLE, thr=THR_INIT, and clear all counters and pipeline valids.
REQ-031 While rst_n=0 at a rising edge, the outputs SHALL be mask_valid=0, mask=0, mask_sof=0, frame_done=0, frame_max=0, skin_count=0, err_sync=0.
REQ-032 Reset mid-frame SHALL drop all in-flight pixels, with no mask_valid output after release until a new sof pixel is accepted.

Verification
REQ-033 IMG_W=4, IMG_H=2, first frame, gauss_A = 0,1,...,7 then 524288..524295 mixed -> mask=0 for all values <=524288; skin_count equals the count of values >524288; 2-cycle latency.
REQ-034 Frame 1 with max 1000 and thr_num=8 -> frame 2 thr=500; gauss_A=500 gives mask 0, gauss_A=501 gives mask 1.
REQ-035 Pixels with in_valid before any sof -> no mask_valid; the first sof pixel produces mask_sof=1 two cycles later.
REQ-036 sof at pixel 3 of 8 -> err_sync pulse, frame_max/skin_count/thr unchanged, new frame completes after 8 more pixels.
REQ-037 Back-to-back frames with a sof pixel in the DONE cycle -> accepted, with the new thr applied, and frame_done pulses once per frame.
REQ-038 rst_n=0 for one cycle mid-frame -> all outputs 0 next cycle, thr=THR_INIT, and the following frame behaves as the first frame.

Source files
------------

// File: rtl/skin_mask_binarizer.sv
// Skin mask binarizer: thresholds gaussian likelihoods against a fraction of the
// previous frame's peak and reports per-frame statistics.
module skin_mask_binarizer #(
  parameter int          IMG_W    = 640,
  parameter int          IMG_H    = 480,
  parameter logic [19:0] THR_INIT = 20'd524288
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic [19:0] gauss_A,
  input  logic [3:0]  thr_num,
  output logic        mask_valid,
  output logic        mask,
  output logic        mask_sof,
  output logic        frame_done,
  output logic [19:0] frame_max,
  output logic [18:0] skin_count,
  output logic        err_sync
);

  localparam logic [18:0] LAST_IDX = 19'(IMG_W * IMG_H - 1);

  // state  | meaning
  // IDLE   | waiting for a sof pixel; other pixels are dropped
  // ACTIVE | frame in progress, every valid pixel is accepted
  // DONE   | one cycle after the last pixel; behaves like IDLE
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t      state, state_nxt;
  logic        accept, start, err_pix, is_last, dec;
  logic [18:0] pix_cnt, pix_idx, run_skin, skin_new;
  logic [19:0] run_max, base_max, max_new, thr;
  logic [23:0] prod;

  logic        s1_valid, s1_mask, s1_sof, s1_last, out_last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACTIVE:  if (is_last) state_nxt = DONE;
      default: begin
        if (start) state_nxt = is_last ? DONE : ACTIVE;
        else       state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    start   = 1'b0;
    err_pix = 1'b0;
    case (state)
      ACTIVE: begin
        accept  = in_valid;
        start   = in_valid & in_sof;
        err_pix = in_valid & in_sof;
      end
      default: begin
        accept = in_valid & in_sof;
        start  = in_valid & in_sof;
      end
    endcase
  end

  // A sof pixel restarts the accumulators, so it is folded in against zero.
  always_comb begin
    pix_idx  = start ? 19'd0 : pix_cnt;
    is_last  = accept && (pix_idx == LAST_IDX);
    dec      = gauss_A > thr;
    base_max = start ? 20'd0 : run_max;
    max_new  = (gauss_A > base_max) ? gauss_A : base_max;
    skin_new = (start ? 19'd0 : run_skin) + {18'd0, dec};
    prod     = {4'd0, max_new} * {20'd0, thr_num};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      run_max    <= '0;
      run_skin   <= '0;
      thr        <= THR_INIT;
      frame_max  <= '0;
      skin_count <= '0;
    end else if (accept) begin
      pix_cnt  <= pix_idx + 19'd1;
      run_max  <= max_new;
      run_skin <= skin_new;
      if (is_last) begin
        thr        <= 20'(prod >> 4);
        frame_max  <= max_new;
        skin_count <= skin_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_mask    <= 1'b0;
      s1_sof     <= 1'b0;
      s1_last    <= 1'b0;
      mask_valid <= 1'b0;
      mask       <= 1'b0;
      mask_sof   <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      s1_valid   <= accept;
      s1_mask    <= accept & dec;
      s1_sof     <= start;
      s1_last    <= is_last;
      mask_valid <= s1_valid;
      mask       <= s1_valid & s1_mask;
      mask_sof   <= s1_valid & s1_sof;
      out_last   <= s1_valid & s1_last;
      frame_done <= mask_valid & out_last;
      err_sync   <= err_pix;
    end
  end

endmodule
